// File: rtl/pfu_if.sv
// ============================================================================
// Module   : pfu_if
// Purpose  : Sample-stream bundle between the IFFT output and the power fix unit.
//            sat_cnt is present only when PFU_SAT_CNT_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pfu_if #(
  parameter int DW_IN  = 12,
  parameter int DW_OUT = 16
);
  logic signed [DW_IN-1:0]  di_re;
  logic signed [DW_IN-1:0]  di_im;
  logic                     di_vld;
  logic                     sym_clr;
  logic signed [DW_OUT-1:0] do_re;
  logic signed [DW_OUT-1:0] do_im;
  logic                     do_vld;
  logic                     do_sop;
`ifdef PFU_SAT_CNT_EN
  logic [15:0]              sat_cnt;
`endif

  modport master (
    output di_re, di_im, di_vld, sym_clr,
    input  do_re, do_im, do_vld, do_sop
`ifdef PFU_SAT_CNT_EN
    , input sat_cnt
`endif
  );

  modport slave (
    input  di_re, di_im, di_vld, sym_clr,
    output do_re, do_im, do_vld, do_sop
`ifdef PFU_SAT_CNT_EN
    , output sat_cnt
`endif
  );
endinterface

`default_nettype wire

// File: rtl/pfu.sv
// ============================================================================
// Module   : pfu
// Purpose  : Power fix unit - scales each complex sample by 22.5 (x*45/2) with
//            round-half-up and saturation in a 3-stage shift-add pipeline, and
//            tags the first sample of each OFDM symbol.
//            Optional saturation counter enabled by macro PFU_SAT_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pfu #(
  parameter int DW_IN  = 12,
  parameter int DW_OUT = 16,
  parameter int NFFT   = 64
) (
  input  logic clk,
  input  logic rst,
  pfu_if.slave bus
);

  localparam int              c_W        = DW_IN + 7;
  localparam int              c_IW       = $clog2(NFFT);
  localparam logic [c_IW-1:0] c_IDX_ZERO = '0;
  localparam logic [c_IW-1:0] c_IDX_ONE  = c_IW'(1);

  // ---------------------------------------------------------------- control
  logic [c_IW-1:0] r_idx;
  logic [c_IW-1:0] w_idx_nxt;
  logic            w_sop0;
  logic            r_v1;
  logic            r_v2;
  logic            r_sop1;
  logic            r_sop2;
  logic            r_do_vld;
  logic            r_do_sop;

  // sym_clr beats di_vld: the colliding sample becomes index 0, so the next is 1
  always_comb begin
    w_idx_nxt = r_idx;
    if (bus.sym_clr) begin
      w_idx_nxt = bus.di_vld ? c_IDX_ONE : c_IDX_ZERO;
    end else if (bus.di_vld) begin
      w_idx_nxt = r_idx + c_IDX_ONE;
    end
  end

  assign w_sop0 = bus.di_vld & ((r_idx == c_IDX_ZERO) | bus.sym_clr);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx    <= '0;
      r_v1     <= 1'b0;
      r_v2     <= 1'b0;
      r_sop1   <= 1'b0;
      r_sop2   <= 1'b0;
      r_do_vld <= 1'b0;
      r_do_sop <= 1'b0;
    end else begin
      r_idx    <= w_idx_nxt;
      r_v1     <= bus.di_vld;
      r_v2     <= r_v1;
      r_sop1   <= w_sop0;
      r_sop2   <= r_sop1;
      r_do_vld <= r_v2;
      r_do_sop <= r_v2 & r_sop2;
    end
  end

  // --------------------------------------------------------------- datapath
  generate
    for (genvar g = 0; g < 2; g++) begin : g_lane
      logic signed [c_W-1:0]    w_xe;
      logic signed [c_W-1:0]    r_p1;
      logic signed [c_W-1:0]    r_p2;
      logic signed [c_W-1:0]    r_r;
      logic signed [DW_OUT-1:0] w_clip;
      logic signed [DW_OUT-1:0] r_out;
      logic                     w_ovf;

      assign w_xe = (g == 0) ? c_W'(bus.di_re) : c_W'(bus.di_im);

      if (c_W > DW_OUT) begin : g_clip
        // in range only when every bit above the output sign bit matches it
        assign w_ovf  = ~((&r_r[c_W-1:DW_OUT-1]) | ~(|r_r[c_W-1:DW_OUT-1]));
        assign w_clip = w_ovf ? (r_r[c_W-1] ? {1'b1, {(DW_OUT-1){1'b0}}}
                                            : {1'b0, {(DW_OUT-1){1'b1}}})
                              : r_r[DW_OUT-1:0];
      end else begin : g_noclip
        assign w_ovf  = 1'b0;
        assign w_clip = DW_OUT'(r_r);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_p1  <= '0;
          r_p2  <= '0;
          r_r   <= '0;
          r_out <= '0;
        end else begin
          r_p1 <= (w_xe <<< 5) + (w_xe <<< 3);
          r_p2 <= (w_xe <<< 2) + w_xe;
          r_r  <= (r_p1 + r_p2 + c_W'(1)) >>> 1;
          if (r_v2) begin
            r_out <= w_clip;
          end
        end
      end
    end
  endgenerate

  assign bus.do_re  = g_lane[0].r_out;
  assign bus.do_im  = g_lane[1].r_out;
  assign bus.do_vld = r_do_vld;
  assign bus.do_sop = r_do_sop;

`ifdef PFU_SAT_CNT_EN
  // ------------------------------------------------------ saturation counter
  logic [15:0] r_sat_cnt;
  logic [1:0]  w_sat_inc;
  logic [16:0] w_sat_sum;

  assign w_sat_inc = r_v2 ? ({1'b0, g_lane[0].w_ovf} + {1'b0, g_lane[1].w_ovf}) : 2'd0;
  assign w_sat_sum = {1'b0, r_sat_cnt} + {15'd0, w_sat_inc};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sat_cnt <= '0;
    end else if (bus.sym_clr) begin
      r_sat_cnt <= '0;
    end else begin
      r_sat_cnt <= w_sat_sum[16] ? 16'hFFFF : w_sat_sum[15:0];
    end
  end

  assign bus.sat_cnt = r_sat_cnt;
`endif

endmodule

`default_nettype wire
